tensor_core_sequencer: RTL and testbench

Sequences a single 4x4 matrix multiply on the small tensor core. It streams 32 operand elements into the tensor core register file through the non-bulk write port, then pulses a start to the tensor core and waits for its done flag. It then streams the 16 result elements back out with a valid/ready handshake. It sits between the CPU-side operand/result streams and the tensor core register file / tensor core pair, replacing instruction-by-instruction element loads.

---
 rtl/tensor_core_sequencer.sv | 130 +++++++++++++
 tb/tb_tensor_core_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_core_sequencer.sv
// Sequences one 4x4 matrix multiply: streams 32 operands into the tensor core
// register file, starts the core, waits for done, then streams 16 results out.
module tensor_core_sequencer #(
  parameter int DATA_WIDTH      = 4,
  parameter int MATRIX_ELEMENTS = 16,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  load_valid_in,
  input  logic [DATA_WIDTH-1:0] load_data_in,
  output logic                  load_ready_out,
  output logic                  regfile_write_enable_out,
  output logic [4:0]            regfile_write_address_out,
  output logic [DATA_WIDTH-1:0] regfile_write_data_out,
  output logic [4:0]            regfile_read_address_out,
  input  logic [DATA_WIDTH-1:0] regfile_read_data_in,
  output logic                  tensor_core_start_out,
  input  logic                  tensor_core_done_in,
  output logic                  result_valid_out,
  output logic [DATA_WIDTH-1:0] result_data_out,
  input  logic                  result_ready_in,
  output logic                  busy_out,
  output logic                  timeout_error_out
);

  localparam int TimerWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [5:0] LastLoad  = 6'(2 * MATRIX_ELEMENTS - 1);
  localparam logic [5:0] LastDrain = 6'(MATRIX_ELEMENTS - 1);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t                state;
  logic [5:0]            count;
  logic [TimerWidth-1:0] timer;
  logic                  load_accept;

  assign load_ready_out = (state == S_IDLE) || (state == S_LOAD);
  assign load_accept    = load_valid_in && load_ready_out;

  // Element k lands at address k; count is 0 in IDLE, so the first accept hits address 0.
  assign regfile_write_enable_out  = load_accept;
  assign regfile_write_address_out = load_accept ? count[4:0] : '0;
  assign regfile_write_data_out    = load_accept ? load_data_in : '0;

  // Result data follows the read address, so it stays stable while count is held.
  assign regfile_read_address_out = (state == S_DRAIN) ? count[4:0] : '0;
  assign result_data_out          = (state == S_DRAIN) ? regfile_read_data_in : '0;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order inside this block.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state                 <= S_IDLE;
      count                 <= '0;
      timer                 <= '0;
      timeout_error_out     <= 1'b0;
      tensor_core_start_out <= 1'b0;
      result_valid_out      <= 1'b0;
      busy_out              <= 1'b0;
    end else begin
      tensor_core_start_out <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (load_accept) begin
            state             <= S_LOAD;
            count             <= 6'd1;
            timeout_error_out <= 1'b0;
            busy_out          <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_accept) begin
            if (count == LastLoad) begin
              state                 <= S_START;
              count                 <= '0;
              tensor_core_start_out <= 1'b1;
            end else begin
              count <= count + 6'd1;
            end
          end
        end
        S_START: begin
          state <= S_WAIT;
          timer <= '0;
        end
        S_WAIT: begin
          // Done is checked first so it wins over a timeout on the same edge.
          if (tensor_core_done_in) begin
            state            <= S_DRAIN;
            count            <= '0;
            result_valid_out <= 1'b1;
          end else if (timer == TimerLast) begin
            state             <= S_IDLE;
            timeout_error_out <= 1'b1;
            busy_out          <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DRAIN: begin
          if (result_ready_in) begin
            if (count == LastDrain) begin
              state            <= S_IDLE;
              count            <= '0;
              result_valid_out <= 1'b0;
              busy_out         <= 1'b0;
            end else begin
              count <= count + 6'd1;
            end
          end
        end
        default: begin
          state            <= S_IDLE;
          count            <= '0;
          result_valid_out <= 1'b0;
          busy_out         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Directed bench for tensor_core_sequencer with a register file and tensor core
// model; every expectation is a hand-derived constant or a bench-built operand table.
module tb_tensor_core_sequencer;

  logic       clock_in;
  logic       reset_in;
  logic       load_valid_in;
  logic [3:0] load_data_in;
  logic       load_ready_out;
  logic       regfile_write_enable_out;
  logic [4:0] regfile_write_address_out;
  logic [3:0] regfile_write_data_out;
  logic [4:0] regfile_read_address_out;
  logic [3:0] regfile_read_data_in;
  logic       tensor_core_start_out;
  logic       tensor_core_done_in;
  logic       result_valid_out;
  logic [3:0] result_data_out;
  logic       result_ready_in;
  logic       busy_out;
  logic       timeout_error_out;

  tensor_core_sequencer dut (
    .clock_in                  (clock_in),
    .reset_in                  (reset_in),
    .load_valid_in             (load_valid_in),
    .load_data_in              (load_data_in),
    .load_ready_out            (load_ready_out),
    .regfile_write_enable_out  (regfile_write_enable_out),
    .regfile_write_address_out (regfile_write_address_out),
    .regfile_write_data_out    (regfile_write_data_out),
    .regfile_read_address_out  (regfile_read_address_out),
    .regfile_read_data_in      (regfile_read_data_in),
    .tensor_core_start_out     (tensor_core_start_out),
    .tensor_core_done_in       (tensor_core_done_in),
    .result_valid_out          (result_valid_out),
    .result_data_out           (result_data_out),
    .result_ready_in           (result_ready_in),
    .busy_out                  (busy_out),
    .timeout_error_out         (timeout_error_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int n_assert = 0;
  int n_fail   = 0;

  // Register file + tensor core model; core_write gates which done pulses compute.
  logic [3:0] rf [32];
  logic       core_write = 1'b0;
  int         wr_q [$];
  logic [3:0] res_q [$];
  int         start_cnt = 0;

  assign regfile_read_data_in = rf[regfile_read_address_out];

  always @(posedge clock_in) begin
    if (regfile_write_enable_out) begin
      rf[regfile_write_address_out] <= regfile_write_data_out;
      wr_q.push_back(int'(regfile_write_address_out));
    end
    if (tensor_core_done_in && core_write) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          int s;
          s = 0;
          for (int k = 0; k < 4; k++)
            s += int'($signed(rf[i*4+k])) * int'($signed(rf[16+k*4+j]));
          rf[i*4+j] <= 4'(s);
        end
      end
    end
    if (tensor_core_start_out) start_cnt <= start_cnt + 1;
    if (result_valid_out && result_ready_in) res_q.push_back(result_data_out);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  logic [3:0] b_mod8 [16];
  logic [3:0] b_neg  [16];
  logic [3:0] b_mix  [16];
  logic [3:0] b_cur  [16];

  function automatic logic [3:0] elem(input int k);
    if (k < 16) return (k % 5 == 0) ? 4'd1 : 4'd0;  // identity A
    return b_cur[k-16];
  endfunction

  task automatic load_range(input int first, input int last, input bit gap, input bit spur);
    for (int k = first; k <= last; k++) begin
      if (gap && k > first) begin
        load_valid_in = 1'b0;
        tick();
      end
      load_valid_in       = 1'b1;
      load_data_in        = elem(k);
      tensor_core_done_in = spur && (k == 5 || k == 6);
      if (k == 31) check("no_start_before_last", {31'd0, tensor_core_start_out}, 32'd0);
      tick();
      if (k == 0) check("err_clear_on_accept", {31'd0, timeout_error_out}, 32'd0);
    end
    load_valid_in       = 1'b0;
    tensor_core_done_in = 1'b0;
  endtask

  task automatic drain(input int stall_at, input bit spur);
    int base;
    base = res_q.size();
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        result_ready_in = 1'b0;
        repeat (5) begin
          tick();
          check("stall_addr", {27'd0, regfile_read_address_out}, i);
          check("stall_data", {28'd0, result_data_out}, {28'd0, b_cur[i]});
          check("stall_valid", {31'd0, result_valid_out}, 32'd1);
        end
        result_ready_in = 1'b1;
      end
      check("res_valid", {31'd0, result_valid_out}, 32'd1);
      check("res_addr", {27'd0, regfile_read_address_out}, i);
      check("res_data", {28'd0, result_data_out}, {28'd0, b_cur[i]});
      tensor_core_done_in = spur && (i % 3 == 0);
      tick();
    end
    tensor_core_done_in = 1'b0;
    check("res_count", res_q.size() - base, 32'd16);
    check("idle_busy", {31'd0, busy_out}, 32'd0);
    check("idle_valid", {31'd0, result_valid_out}, 32'd0);
    check("idle_ready", {31'd0, load_ready_out}, 32'd1);
  endtask

  task automatic check_writes(input int base);
    check("wr_count", wr_q.size() - base, 32'd32);
    for (int i = 0; i < 32; i++)
      if (base + i < wr_q.size()) check("wr_addr", wr_q[base+i], i);
  endtask

  // One full job: load (optionally gapped), start, done after 3 cycles, drain.
  task automatic run_job(input bit gap, input bit spur_load, input int stall_at, input bit spur_drain);
    int wr_base;
    int st_base;
    wr_base = wr_q.size();
    st_base = start_cnt;
    load_range(0, 31, gap, spur_load);
    check("start_pulse", {31'd0, tensor_core_start_out}, 32'd1);
    check("start_busy", {31'd0, busy_out}, 32'd1);
    check("start_not_ready", {31'd0, load_ready_out}, 32'd0);
    tick();
    check("start_one_cycle", {31'd0, tensor_core_start_out}, 32'd0);
    repeat (2) tick();
    core_write          = 1'b1;
    tensor_core_done_in = 1'b1;
    tick();
    core_write          = 1'b0;
    tensor_core_done_in = 1'b0;
    check_writes(wr_base);
    check("start_count", start_cnt - st_base, 32'd1);
    drain(stall_at, spur_drain);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      b_mod8[k] = 4'(k % 8);
      b_neg[k]  = 4'(15 - k);
      b_mix[k]  = 4'(k * 3 + 1);
      rf[k]      = 4'd0;
      rf[k + 16] = 4'd0;
    end
    reset_in            = 1'b1;
    load_valid_in       = 1'b0;
    load_data_in        = 4'd0;
    tensor_core_done_in = 1'b0;
    result_ready_in     = 1'b1;
    repeat (2) tick();
    check("rst_ready", {31'd0, load_ready_out}, 32'd1);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_start", {31'd0, tensor_core_start_out}, 32'd0);
    check("rst_valid", {31'd0, result_valid_out}, 32'd0);
    check("rst_err", {31'd0, timeout_error_out}, 32'd0);
    check("rst_raddr", {27'd0, regfile_read_address_out}, 32'd0);
    check("rst_we", {31'd0, regfile_write_enable_out}, 32'd0);
    reset_in = 1'b0;
    tick();

    // Identity multiply: results equal B.
    b_cur = b_mod8;
    run_job(1'b0, 1'b0, -1, 1'b0);

    // Gapped loads with result backpressure at element 7.
    b_cur = b_neg;
    run_job(1'b1, 1'b0, 7, 1'b0);

    // Spurious done during LOAD and DRAIN.
    b_cur = b_mix;
    run_job(1'b0, 1'b1, -1, 1'b1);

    // Timeout: done never arrives.
    begin
      int res_base;
      res_base = res_q.size();
      b_cur = b_mod8;
      load_range(0, 31, 1'b0, 1'b0);
      tick();
      for (int c = 1; c < 64; c++) begin
        tick();
        if (c == 1 || c == 62 || c == 63)
          check("to_not_yet", {31'd0, timeout_error_out}, 32'd0);
      end
      tick();
      check("to_err", {31'd0, timeout_error_out}, 32'd1);
      check("to_idle_busy", {31'd0, busy_out}, 32'd0);
      check("to_idle_ready", {31'd0, load_ready_out}, 32'd1);
      check("to_no_result", res_q.size() - res_base, 32'd0);
      tick();
      check("to_err_sticky", {31'd0, timeout_error_out}, 32'd1);
    end

    // Next job clears the flag on its first accept and completes normally.
    b_cur = b_neg;
    run_job(1'b0, 1'b0, -1, 1'b0);

    // Done on the same edge the timeout would fire wins.
    b_cur = b_mix;
    load_range(0, 31, 1'b0, 1'b0);
    tick();
    repeat (63) tick();
    core_write          = 1'b1;
    tensor_core_done_in = 1'b1;
    tick();
    core_write          = 1'b0;
    tensor_core_done_in = 1'b0;
    check("race_no_err", {31'd0, timeout_error_out}, 32'd0);
    check("race_drain", {31'd0, result_valid_out}, 32'd1);
    drain(-1, 1'b0);

    // Reset after 10 accepts abandons the job.
    b_cur = b_mod8;
    load_range(0, 9, 1'b0, 1'b0);
    check("mid_busy", {31'd0, busy_out}, 32'd1);
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check("mrst_ready", {31'd0, load_ready_out}, 32'd1);
    check("mrst_busy", {31'd0, busy_out}, 32'd0);
    check("mrst_start", {31'd0, tensor_core_start_out}, 32'd0);
    check("mrst_valid", {31'd0, result_valid_out}, 32'd0);
    check("mrst_we", {31'd0, regfile_write_enable_out}, 32'd0);
    check("mrst_waddr", {27'd0, regfile_write_address_out}, 32'd0);
    b_cur = b_neg;
    run_job(1'b0, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
